// File: rtl/r2r_sar_pkg.sv
// Shared types and default constants for the R2R successive-approximation ADC.
package r2r_sar_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DECIDE = 2'd2,
        DONE   = 2'd3
    } sar_state_t;

    localparam int DEF_WIDTH          = 8;
    localparam int DEF_SETTLE_CYCLES  = 1000;
    localparam int DEF_AVG_LOG2       = 4;
    localparam int DEF_SCALING_FACTOR = 13252;
    localparam int DEF_SHIFT_FACTOR   = 10;

    // Width of the millivolt output.
    localparam int SCALED_W = 16;

endpackage

// File: rtl/sar_avg_scale.sv
// Block averager and millivolt scaler for completed SAR conversions.
// data/data_valid arrive in the DONE cycle, so ave_data lands on the same
// edge that publishes the raw result; the scaled value follows one edge later.
module sar_avg_scale
    import r2r_sar_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int AVG_LOG2       = DEF_AVG_LOG2,
    parameter int SCALING_FACTOR = DEF_SCALING_FACTOR,
    parameter int SHIFT_FACTOR   = DEF_SHIFT_FACTOR
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic [WIDTH-1:0]    data,
    input  logic                data_valid,
    output logic [WIDTH-1:0]    ave_data,
    output logic [SCALED_W-1:0] scaled_adc_data,
    output logic                scaled_valid
);

    localparam int ACC_W = WIDTH + AVG_LOG2;

    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [AVG_LOG2-1:0] n_samp;
    logic [1:0]          vld_pipe;   // [0]: ave_data updated, [1]: scaled updated
    logic [31:0]         product;
    logic [31:0]         shifted;
    logic [SCALED_W-1:0] scaled_sat;

    assign acc_sum    = acc + ACC_W'(data);
    assign product    = 32'(ave_data) * 32'(SCALING_FACTOR);
    assign shifted    = product >> SHIFT_FACTOR;
    assign scaled_sat = (shifted > 32'(16'hFFFF)) ? '1 : shifted[SCALED_W-1:0];

    assign scaled_valid = vld_pipe[1];

    // Accumulate samples; publish the truncated mean when a block completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc         <= '0;
            n_samp      <= '0;
            ave_data    <= '0;
            vld_pipe[0] <= 1'b0;
        end else begin
            vld_pipe[0] <= 1'b0;
            if (clear) begin
                acc    <= '0;
                n_samp <= '0;
            end else if (data_valid) begin
                if (n_samp == '1) begin
                    ave_data    <= WIDTH'(acc_sum >> AVG_LOG2);
                    acc         <= '0;
                    n_samp      <= '0;
                    vld_pipe[0] <= 1'b1;
                end else begin
                    acc    <= acc_sum;
                    n_samp <= n_samp + 1'b1;
                end
            end
        end
    end

    // Registered multiply/shift with saturation, one edge behind ave_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scaled_adc_data <= '0;
            vld_pipe[1]     <= 1'b0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            if (vld_pipe[0])
                scaled_adc_data <= scaled_sat;
        end
    end

endmodule

// File: rtl/r2r_sar_adc.sv
// SAR front end for the external R2R ladder: comparator synchronizer,
// binary-search FSM, trial register and per-bit settle counter.
module r2r_sar_adc
    import r2r_sar_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int AVG_LOG2       = DEF_AVG_LOG2,
    parameter int SCALING_FACTOR = DEF_SCALING_FACTOR,
    parameter int SHIFT_FACTOR   = DEF_SHIFT_FACTOR
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                comp_in,
    output logic [WIDTH-1:0]    r2r_out,
    output logic [WIDTH-1:0]    data,
    output logic                data_valid,
    output logic [WIDTH-1:0]    ave_data,
    output logic [SCALED_W-1:0] scaled_adc_data,
    output logic                scaled_valid
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    sar_state_t       state, state_nxt;
    logic [1:0]       sync;
    logic             comp_s;
    logic [WIDTH-1:0] trial;
    logic [WIDTH-1:0] trial_dec;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             abort;
    logic             done;

    assign comp_s  = sync[1];
    // Ladder only sees the trial code while a bit is being tested.
    assign r2r_out = (state == SETTLE || state == DECIDE) ? trial : '0;

    // Two-flop synchronizer for the asynchronous comparator output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= '0;
        else       sync <= {sync[0], comp_in};
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; enable low mid-search aborts, DONE always completes.
    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:   if (enable) state_nxt = SETTLE;
            SETTLE: begin
                if (!enable) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = DECIDE;
                end
            end
            DECIDE: begin
                if (!enable) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (idx == '0) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = SETTLE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Trial update for the bit under test: drop it if Vin is below the
    // ladder, then raise the next lower bit for the following trial.
    always_comb begin
        trial_dec = trial;
        if (!comp_s)
            trial_dec[idx] = 1'b0;
        if (idx != '0)
            trial_dec[idx - 1'b1] = 1'b1;
    end

    // Trial register, bit index, settle counter and result publication.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trial      <= '0;
            idx        <= '0;
            cnt        <= '0;
            data       <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= done;
            if (done)
                data <= trial;
            case (state)
                IDLE: begin
                    if (enable) begin
                        trial <= {1'b1, {(WIDTH-1){1'b0}}};
                        idx   <= IDX_W'(WIDTH - 1);
                        cnt   <= '0;
                    end
                end
                SETTLE: cnt <= cnt + 1'b1;
                DECIDE: begin
                    if (enable) begin
                        trial <= trial_dec;
                        if (idx != '0) begin
                            idx <= idx - 1'b1;
                            cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    sar_avg_scale #(
        .WIDTH          (WIDTH),
        .AVG_LOG2       (AVG_LOG2),
        .SCALING_FACTOR (SCALING_FACTOR),
        .SHIFT_FACTOR   (SHIFT_FACTOR)
    ) u_avg_scale (
        .clk             (clk),
        .reset           (reset),
        .clear           (abort),
        .data            (trial),
        .data_valid      (done),
        .ave_data        (ave_data),
        .scaled_adc_data (scaled_adc_data),
        .scaled_valid    (scaled_valid)
    );

endmodule

// File: tb/tb_r2r_sar_adc.sv
// Bench for r2r_sar_adc with a short settle time and a behavioural
// comparator (Vin_code >= r2r_out, two register delay). Expected codes,
// averages and scaled values are queued as each conversion is launched
// and popped when the DUT reports them.
module tb_r2r_sar_adc;

    localparam int W  = 8;
    localparam int SC = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         comp_in = 1'b0;
    logic [W-1:0] r2r_out, data, ave_data;
    logic         data_valid, scaled_valid;
    logic [15:0]  scaled_adc_data;

    logic [7:0]   vin = 8'h00;
    logic         comp_d1 = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  ave_q[$];
    logic [15:0] scl_q[$];
    int          m_sum = 0;
    int          m_n   = 0;
    logic        prev_dv = 1'b0;

    r2r_sar_adc #(
        .WIDTH         (W),
        .SETTLE_CYCLES (SC),
        .AVG_LOG2      (4),
        .SCALING_FACTOR(13252),
        .SHIFT_FACTOR  (10)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .comp_in        (comp_in),
        .r2r_out        (r2r_out),
        .data           (data),
        .data_valid     (data_valid),
        .ave_data       (ave_data),
        .scaled_adc_data(scaled_adc_data),
        .scaled_valid   (scaled_valid)
    );

    always #5 clk = ~clk;

    // Comparator model: output reflects the ladder two clocks earlier.
    always @(posedge clk) begin
        comp_d1 <= (vin >= r2r_out);
        comp_in <= comp_d1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model of averaging and scaling, fed at launch time.
    task automatic push_exp(input logic [7:0] v);
        int a, s;
        exp_q.push_back(v);
        m_sum += v;
        m_n++;
        if (m_n == 16) begin
            a = m_sum / 16;
            s = (a * 13252) / 1024;
            if (s > 65535) s = 65535;
            ave_q.push_back(8'(a));
            scl_q.push_back(16'(s));
            m_sum = 0;
            m_n   = 0;
        end
    endtask

    task automatic model_clear();
        m_sum = 0;
        m_n   = 0;
    endtask

    // Launch one conversion and wait for its data_valid; cyc = cycles taken.
    task automatic conv(input logic [7:0] v, output int cyc);
        vin    = v;
        enable = 1'b1;
        push_exp(v);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!data_valid && cyc < 200);
        if (!data_valid) chk("conv_timeout", {31'd0, data_valid}, 1);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!reset) begin
            if (data_valid) begin
                if (exp_q.size() == 0) chk("dv_unexpected", 1, 0);
                else                   chk("data", data, exp_q.pop_front());
            end
            if (scaled_valid) begin
                chk("sv_after_dv", {31'd0, prev_dv}, 1);
                if (scl_q.size() == 0) chk("sv_unexpected", 1, 0);
                else begin
                    chk("ave", ave_data, ave_q.pop_front());
                    chk("scaled", scaled_adc_data, scl_q.pop_front());
                end
            end
            prev_dv <= data_valid;
        end else begin
            prev_dv <= 1'b0;
        end
    end

    initial begin
        int cyc, t, t_set, t_dv, nlad, ndv;
        logic [7:0] last;
        logic [7:0] lad[8];
        logic [7:0] exp_lad[8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_r2r", r2r_out, 0);
        chk("rst_data", data, 0);
        chk("rst_dv", {31'd0, data_valid}, 0);
        chk("rst_ave", ave_data, 0);
        chk("rst_scaled", scaled_adc_data, 0);
        chk("rst_sv", {31'd0, scaled_valid}, 0);
        reset = 1'b0;
        @(negedge clk);

        // First conversion of 0xA5: ladder sequence and latency.
        vin = 8'hA5;
        push_exp(8'hA5);
        enable = 1'b1;
        t = 0; t_set = -1; t_dv = -1; nlad = 0; last = 8'h00;
        while (t_dv < 0 && t < 200) begin
            @(negedge clk);
            t++;
            if (r2r_out != 0 && r2r_out != last) begin
                if (nlad < 8) lad[nlad] = r2r_out;
                nlad++;
            end
            last = r2r_out;
            if (t_set < 0 && r2r_out != 0) t_set = t;
            if (data_valid) t_dv = t;
        end
        chk("dv_from_settle", t_dv - t_set, W * (SC + 1) + 1);
        chk("dv_from_enable", t_dv, 42);
        chk("ladder_len", nlad, 8);
        for (int i = 0; i < 8; i++) chk("ladder", lad[i], exp_lad[i]);

        // Back-to-back period with enable held high.
        conv(8'hA5, cyc);
        chk("period", cyc, 42);

        // Abort 20 cycles into the next conversion.
        repeat (20) @(negedge clk);
        chk("r2r_before_abort", {31'd0, (r2r_out != 0)}, 1);
        enable = 1'b0;
        model_clear();
        @(negedge clk);
        chk("r2r_after_abort", r2r_out, 0);
        ndv = 0;
        repeat (60) begin
            @(negedge clk);
            if (data_valid) ndv++;
        end
        chk("abort_no_dv", ndv, 0);
        chk("abort_data_hold", data, 8'hA5);

        // Full-scale block: 0xFF -> 0xFF / 3300 mV.
        for (int i = 0; i < 16; i++) conv(8'hFF, cyc);
        @(negedge clk);
        chk("sv_ff", {31'd0, scaled_valid}, 1);
        chk("ave_ff", ave_data, 8'hFF);
        chk("scaled_ff", scaled_adc_data, 3300);

        // Zero block.
        for (int i = 0; i < 16; i++) conv(8'h00, cyc);
        @(negedge clk);
        chk("ave_00", ave_data, 0);
        chk("scaled_00", scaled_adc_data, 0);

        // Alternating 0x10 / 0x20 -> 0x18 / 310 mV.
        for (int i = 0; i < 16; i++) conv((i % 2 == 0) ? 8'h10 : 8'h20, cyc);
        @(negedge clk);
        chk("ave_alt", ave_data, 8'h18);
        chk("scaled_alt", scaled_adc_data, 310);

        // Reset in the middle of SETTLE of the following conversion.
        repeat (2) @(negedge clk);
        chk("r2r_pre_reset", {31'd0, (r2r_out != 0)}, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_r2r", r2r_out, 0);
        chk("mid_rst_data", data, 0);
        chk("mid_rst_ave", ave_data, 0);
        chk("mid_rst_scaled", scaled_adc_data, 0);
        chk("mid_rst_dv", {31'd0, data_valid}, 0);
        chk("mid_rst_sv", {31'd0, scaled_valid}, 0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        conv(8'h33, cyc);
        chk("post_reset_latency", cyc, 42);

        @(negedge clk);
        chk("sb_data_empty", exp_q.size(), 0);
        chk("sb_scaled_empty", scl_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
